mul_window_tiled: RTL and testbench
===================================

# mul_window_tiled

Parametrised, time-multiplexed unsigned multiplier:
- Splits operands into DSP-sized tiles and issues `LANES` partial products per cycle.
- Accumulates the shifted partial products into a full-width product.
- Returns both a selectable bit window and the full product, behind valid/ready handshakes.
- Generalised successor to the fixed 110-bit upper-two-bit multiplier in the modular-reduction datapath: trades DSP count against latency and adds flow control.

## Interface

Parameters:
- `MUL_W`, 110, operand width (bits).
- `A_TILE`, 25, a-tile width (DSP A port).
- `B_TILE`, 16, b-tile width (DSP B port).
- `LANES`, 35, partial products issued per cycle; range 1..`NA*NB`.
- `RES_LSB`, 218, LSB of output window; `RES_LSB+RES_W <= 2*MUL_W` is required.
- `RES_W`, 2, output window width.
- Derived:
  - `NA = ceil(MUL_W/A_TILE)`, `NB = ceil(MUL_W/B_TILE)`
  - `NPP = NA*NB`, `K = ceil(NPP/LANES)`

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  `MUL_W`  multiplicand, unsigned.
- `b`  in  `MUL_W`  multiplier, unsigned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `res`  out  `RES_W`  `prod[RES_LSB+RES_W-1:RES_LSB]`.
- `prod`  out  `2*MUL_W`  full product `a*b`.

## Operation

- **Tiling**
  - a-tile i = `a[i*A_TILE +: A_TILE]`; b-tile j = `b[j*B_TILE +: B_TILE]`.
  - The last tile of each operand is zero-extended.
  - Partial product index `p = i*NB + j`; its weight is `2^(i*A_TILE + j*B_TILE)`.
- **Issue groups**
  - Group g covers `p = g*LANES .. g*LANES+LANES-1`.
  - Lanes with `p >= NPP` contribute zero.
  - Each lane multiplier is `A_TILE x B_TILE` and is registered; one lane maps to one DSP.
- **Accumulator**
  - Width `2*MUL_W`; sums all shifted lane products of a group in one cycle.
  - Bits above `2*MUL_W-1` are discarded; they cannot be set for a valid product.
- **FSM**
  - `IDLE`
    - `in_ready=1`.
    - On `in_valid`: latch `a`/`b`, clear the accumulator, clear the group counter, go to `MUL`.
  - `MUL`
    - Issue group g each cycle, g = 0..K-1, then increment g.
    - After issuing group K-1, go to `DRAIN`.
  - `DRAIN`
    - One cycle: the last group's registered products are added.
    - Go to `DONE`.
  - `DONE`
    - `out_valid=1`; `res` and `prod` are stable.
    - On `out_ready`, go to `IDLE`.
- **Register outputs**
  - `in_ready = (state==IDLE)` and `out_valid = (state==DONE)`, both registered-state decoded.
  - `res`/`prod` come straight from the accumulator register and change only while state is `MUL`/`DRAIN`.
- **Reset values**
  - Reset (`rst_n=0` at a clk edge) forces `IDLE`.
  - Accumulator, lane registers, group counter and latched operands all go to 0.
  - Outputs after reset: `in_ready=1`, `out_valid=0`, `res=0`, `prod=0`.

## Timing

- Accept edge E0: `in_valid & in_ready`.
- Group g products are registered at E(g+1) and accumulated at E(g+2).
- Last accumulation is at E(K+1); `out_valid=1` from E(K+1).
- Latency is K+1 cycles from accept to `out_valid`. Default config: K=1, so latency 2.
- Output handshake completes at the edge with `out_valid & out_ready`. `IDLE` (`in_ready=1`) follows that edge.
  - Minimum initiation interval is K+3 cycles.
  - `in_ready` and `out_valid` are never high together.
- Boundary behaviour:
  - **`out_ready` low:** hold `DONE` indefinitely; `res`/`prod` stay stable.
  - **`in_valid` outside `IDLE`:** ignored; operand changes after E0 have no effect.
  - **Reset mid-`MUL`/`DRAIN`/`DONE`:** transaction discarded. No `out_valid` for it; `IDLE` is reached the cycle after reset deasserts.
  - **`LANES` not dividing `NPP`:** the final group is partially filled; the result is unchanged.
  - **Zero operand:** `prod=0`, `res=0`, same latency.

## Test plan

- **Default params, all-ones operands:** `a=b=2^110-1` -> `prod=2^220-2^111+1`, `res=2'b11`, `out_valid` 2 cycles after accept.
- **Single-bit and small operands, default params:**
  - `a=b=2^109` -> `prod=2^218`, `res=2'b01`.
  - `a=3`, `b=5` -> `prod=15`, `res=2'b00`.
- **`LANES=8` (K=5), random 110-bit operands:**
  - Check `prod` against a reference model and latency = 6 cycles.
  - Run 1000 transactions back-to-back with `out_ready=1`.
  - Initiation interval must be exactly 8 cycles.
- **Backpressure:**
  - Hold `out_ready=0` for 10 cycles after `out_valid`: `res`/`prod` stable, `in_ready=0`.
  - Toggle `a`/`b`/`in_valid` during the hold: no effect.
  - Release -> `IDLE` next cycle.
- **Reset mid-operation, `LANES=1` (K=35):**
  - Assert `rst_n=0` for one cycle at group 10 -> `out_valid` never rises for that job, outputs 0.
  - The next accepted job `a=b=2^109` gives `res=2'b01`.
- **Window parameters:** `MUL_W=64`, `RES_LSB=60`, `RES_W=8`, `a=b=2^63` -> `prod=2^126`, `res=8'h00`. `a=b=2^33` -> `prod=2^66`, `res=8'h40`.

Source files
------------

// File: rtl/mul_window_tiled.sv
// Time-multiplexed unsigned multiplier: DSP-sized partial products are issued LANES per cycle,
// accumulated into the full product, and returned with a selectable bit window.
module mul_window_tiled #(
   parameter int unsigned MUL_W   = 110,
   parameter int unsigned A_TILE  = 25,
   parameter int unsigned B_TILE  = 16,
   parameter int unsigned LANES   = 35,
   parameter int unsigned RES_LSB = 218,
   parameter int unsigned RES_W   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MUL_W-1:0]   a,
   input  logic [MUL_W-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [RES_W-1:0]   res,
   output logic [2*MUL_W-1:0] prod
);

   localparam int unsigned NA    = (MUL_W + A_TILE - 1) / A_TILE;
   localparam int unsigned NB    = (MUL_W + B_TILE - 1) / B_TILE;
   localparam int unsigned NPP   = NA * NB;
   localparam int unsigned K     = (NPP + LANES - 1) / LANES;
   localparam int unsigned ACC_W = 2 * MUL_W;
   localparam int unsigned PP_W  = A_TILE + B_TILE;
   localparam int unsigned SH_W  = $clog2(ACC_W);
   localparam int unsigned GW    = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned AP_W  = NA * A_TILE;
   localparam int unsigned BP_W  = NB * B_TILE;

   typedef enum logic [1:0] {StIdle, StMul, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [MUL_W-1:0]  a_q, a_d;
   logic [MUL_W-1:0]  b_q, b_d;
   logic [GW-1:0]     grp_q, grp_d;
   logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
   logic [PP_W-1:0]   lane_q [LANES];
   logic [PP_W-1:0]   lane_d [LANES];
   logic [SH_W-1:0]   sh_q [LANES];
   logic [SH_W-1:0]   sh_d [LANES];
   logic              lane_vld_q, lane_vld_d;
   logic [AP_W-1:0]   a_pad;
   logic [BP_W-1:0]   b_pad;
   int unsigned       grp_base, pp_idx, ti, tj;

   // Lane issue: each lane owns one A_TILE x B_TILE product plus the weight it carries.
   always_comb begin
      a_pad            = '0;
      a_pad[MUL_W-1:0] = a_q;
      b_pad            = '0;
      b_pad[MUL_W-1:0] = b_q;
      grp_base         = 32'(grp_q) * LANES;
      pp_idx           = 0;
      ti               = 0;
      tj               = 0;
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_d[l] = lane_q[l];
         sh_d[l]   = sh_q[l];
         if (state_q == StMul) begin
            pp_idx = grp_base + l;
            if (pp_idx < NPP) begin
               ti        = pp_idx / NB;
               tj        = pp_idx % NB;
               lane_d[l] = PP_W'(a_pad[ti*A_TILE +: A_TILE]) * PP_W'(b_pad[tj*B_TILE +: B_TILE]);
               sh_d[l]   = SH_W'(ti * A_TILE + tj * B_TILE);
            end else begin
               lane_d[l] = '0;
               sh_d[l]   = '0;
            end
         end
      end
   end

   // Sum of one group's shifted products; carries out of ACC_W cannot occur for a valid product.
   always_comb begin
      acc_sum = acc_q;
      for (int unsigned l = 0; l < LANES; l++) begin
         acc_sum = acc_sum + (ACC_W'(lane_q[l]) << sh_q[l]);
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      grp_d      = grp_q;
      acc_d      = acc_q;
      lane_vld_d = (state_q == StMul);
      if (lane_vld_q) begin
         acc_d = acc_sum;
      end
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               grp_d   = '0;
               state_d = StMul;
            end
         end
         StMul: begin
            if (grp_q == GW'(K - 1)) begin
               state_d = StDrain;
            end else begin
               grp_d = grp_q + 1'b1;
            end
         end
         StDrain: state_d = StDone;
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      in_ready_d  = (state_d == StIdle);
      out_valid_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         grp_q       <= '0;
         acc_q       <= '0;
         lane_vld_q  <= 1'b0;
         for (int unsigned l = 0; l < LANES; l++) begin
            lane_q[l] <= '0;
            sh_q[l]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         grp_q       <= grp_d;
         acc_q       <= acc_d;
         lane_vld_q  <= lane_vld_d;
         for (int unsigned l = 0; l < LANES; l++) begin
            lane_q[l] <= lane_d[l];
            sh_q[l]   <= sh_d[l];
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign prod      = acc_q;
   assign res       = acc_q[RES_LSB +: RES_W];

endmodule

// File: tb/tb_mul_window_tiled.sv
// Bench for mul_window_tiled: vector table, scoreboard run at LANES=8, backpressure,
// mid-job reset at LANES=1 and a 64-bit windowed configuration.
module tb_mul_window_tiled;

   localparam int unsigned W  = 110;
   localparam int unsigned PW = 220;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst_n;
   logic [W-1:0]          a, b;
   logic [2:0]            iv, ordy, irdy, ov;
   logic [2:0][1:0]       rs;
   logic [2:0][PW-1:0]    pr;

   logic [63:0]  aw, bw;
   logic         ivw, ordyw, irdyw, ovw;
   logic [7:0]   rsw;
   logic [127:0] prw;

   int checks = 0;
   int errors = 0;

   mul_window_tiled #(.LANES(35)) u_l35 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a), .b(b),
      .out_valid(ov[0]), .out_ready(ordy[0]), .res(rs[0]), .prod(pr[0])
   );
   mul_window_tiled #(.LANES(8)) u_l8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a), .b(b),
      .out_valid(ov[1]), .out_ready(ordy[1]), .res(rs[1]), .prod(pr[1])
   );
   mul_window_tiled #(.LANES(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a), .b(b),
      .out_valid(ov[2]), .out_ready(ordy[2]), .res(rs[2]), .prod(pr[2])
   );
   mul_window_tiled #(.MUL_W(64), .LANES(5), .RES_LSB(60), .RES_W(8)) u_win (
      .clk(clk), .rst_n(rst_n), .in_valid(ivw), .in_ready(irdyw), .a(aw), .b(bw),
      .out_valid(ovw), .out_ready(ordyw), .res(rsw), .prod(prw)
   );

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] mul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [PW-1:0] xw, yw;
      xw = PW'(x);
      yw = PW'(y);
      return xw * yw;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      return W'({$urandom, $urandom, $urandom, $urandom});
   endfunction

   // Called #1 after an edge with instance k idle; returns result and accept-to-valid latency.
   task automatic run_job(input int k, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          output logic [PW-1:0] p, output logic [1:0] r, output int lat);
      a       = ta;
      b       = tb_v;
      iv[k]   = 1'b1;
      ordy[k] = 1'b1;
      @(posedge clk); #1;
      iv[k] = 1'b0;
      lat   = 0;
      while (!ov[k] && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      p = pr[k];
      r = rs[k];
      @(posedge clk); #1;
   endtask

   task automatic run_w(input logic [63:0] ta, input logic [63:0] tb_v,
                        output logic [127:0] p, output logic [7:0] r, output int lat);
      aw    = ta;
      bw    = tb_v;
      ivw   = 1'b1;
      ordyw = 1'b1;
      @(posedge clk); #1;
      ivw = 1'b0;
      lat = 0;
      while (!ovw && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      p = prw;
      r = rsw;
      @(posedge clk); #1;
   endtask

   typedef struct {
      int            k;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [PW-1:0] prod;
      logic [1:0]    res;
      int            lat;
   } vec_t;

   vec_t vt[6];

   initial begin
      logic [W-1:0]   ones, p109;
      logic [PW-1:0]  one_w, p1, p218, exp_p, got_p;
      logic [1:0]     got_r;
      logic [127:0]   got_w, exp_w;
      logic [7:0]     got_rw;
      logic [63:0]    ta_w, tb_w;
      int             lat, cyc, n_acc, last_acc, n_out, seen_ov;
      logic           do_acc;
      logic [PW-1:0]  sb_q[$];
      int             acc_cyc_q[$];

      ones  = '1;
      p109  = W'(1) << 109;
      one_w = PW'(1);
      p1    = '0;
      p1    = p1 - (one_w << 111) + one_w;
      p218  = one_w << 218;

      vt[0] = '{0, ones, ones, p1, 2'b11, 2};
      vt[1] = '{0, p109, p109, p218, 2'b01, 2};
      vt[2] = '{0, W'(3), W'(5), PW'(15), 2'b00, 2};
      vt[3] = '{0, W'(0), ones, PW'(0), 2'b00, 2};
      vt[4] = '{1, ones, ones, p1, 2'b11, 6};
      vt[5] = '{1, W'(0), W'(0), PW'(0), 2'b00, 6};

      rst_n = 1'b0;
      a = '0; b = '0; iv = '0; ordy = '0;
      aw = '0; bw = '0; ivw = 1'b0; ordyw = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset in_ready", PW'(irdy), PW'(3'b111));
      chk("reset out_valid", PW'(ov), PW'(0));
      chk("reset prod l35", pr[0], PW'(0));
      chk("reset prod l1", pr[2], PW'(0));
      chk("reset res", PW'(rs), PW'(0));
      chk("reset win", PW'({irdyw, ovw, rsw, prw}), PW'({1'b1, 137'b0}));

      for (int i = 0; i < 6; i++) begin
         chk($sformatf("vec%0d idle", i), PW'(irdy[vt[i].k]), PW'(1));
         run_job(vt[i].k, vt[i].a, vt[i].b, got_p, got_r, lat);
         chk($sformatf("vec%0d prod", i), got_p, vt[i].prod);
         chk($sformatf("vec%0d res", i), PW'(got_r), PW'(vt[i].res));
         chk($sformatf("vec%0d latency", i), PW'(lat), PW'(vt[i].lat));
         chk($sformatf("vec%0d back to idle", i), PW'({irdy[vt[i].k], ov[vt[i].k]}), PW'(2'b10));
      end

      // Backpressure on the LANES=8 instance, with operand and in_valid noise while held.
      a = rnd_op();
      b = rnd_op();
      exp_p = mul_ref(a, b);
      iv[1] = 1'b1;
      ordy[1] = 1'b0;
      @(posedge clk); #1;
      iv[1] = 1'b0;
      lat = 0;
      while (!ov[1] && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp latency", PW'(lat), PW'(6));
      for (int i = 0; i < 10; i++) begin
         a = rnd_op();
         b = rnd_op();
         iv[1] = ~iv[1];
         @(posedge clk); #1;
         chk($sformatf("bp hold prod %0d", i), pr[1], exp_p);
         chk($sformatf("bp hold flags %0d", i), PW'({irdy[1], ov[1]}), PW'(2'b01));
      end
      iv[1] = 1'b0;
      ordy[1] = 1'b1;
      @(posedge clk); #1;
      chk("bp release idle", PW'({irdy[1], ov[1]}), PW'(2'b10));
      chk("bp release prod", pr[1], exp_p);

      // Reset in the middle of a LANES=1 job.
      a = ones;
      b = ones;
      iv[2] = 1'b1;
      ordy[2] = 1'b1;
      @(posedge clk); #1;
      iv[2] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("mid-job busy", PW'(irdy[2]), PW'(0));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid-reset flags", PW'({irdy[2], ov[2]}), PW'(2'b10));
      chk("mid-reset prod", pr[2], PW'(0));
      chk("mid-reset res", PW'(rs[2]), PW'(0));
      seen_ov = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (ov[2]) seen_ov++;
      end
      chk("no out_valid after reset", PW'(seen_ov), PW'(0));
      run_job(2, p109, p109, got_p, got_r, lat);
      chk("post-reset res", PW'(got_r), PW'(2'b01));
      chk("post-reset prod", got_p, p218);
      chk("post-reset latency", PW'(lat), PW'(36));

      // Windowed 64-bit instance, partially filled final group.
      run_w(64'd1 << 63, 64'd1 << 63, got_w, got_rw, lat);
      chk("win 2^63 prod", PW'(got_w), PW'(128'd1 << 126));
      chk("win 2^63 res", PW'(got_rw), PW'(8'h00));
      chk("win latency", PW'(lat), PW'(4));
      run_w(64'd1 << 33, 64'd1 << 33, got_w, got_rw, lat);
      chk("win 2^33 prod", PW'(got_w), PW'(128'd1 << 66));
      chk("win 2^33 res", PW'(got_rw), PW'(8'h40));
      for (int i = 0; i < 4; i++) begin
         ta_w = {$urandom, $urandom};
         tb_w = {$urandom, $urandom};
         exp_w = {64'd0, ta_w} * {64'd0, tb_w};
         run_w(ta_w, tb_w, got_w, got_rw, lat);
         chk($sformatf("win rand%0d prod", i), PW'(got_w), PW'(exp_w));
         chk($sformatf("win rand%0d res", i), PW'(got_rw), PW'(exp_w[67:60]));
      end

      // Back-to-back scoreboard run on the LANES=8 instance.
      cyc = 0; n_acc = 0; n_out = 0; last_acc = -1;
      a = rnd_op();
      b = rnd_op();
      iv[1] = 1'b1;
      ordy[1] = 1'b1;
      while ((n_acc < 1000 || sb_q.size() > 0) && cyc < 20000) begin
         if (n_acc >= 1000) iv[1] = 1'b0;
         do_acc = iv[1] & irdy[1];
         if (irdy[1] && ov[1]) chk("ready and valid together", PW'(1), PW'(0));
         if (ov[1]) begin
            if (sb_q.size() == 0) begin
               chk("unexpected out_valid", PW'(1), PW'(0));
            end else begin
               chk("sb prod", pr[1], sb_q.pop_front());
               chk("sb latency", PW'(cyc - acc_cyc_q.pop_front()), PW'(6));
               n_out++;
            end
         end
         @(posedge clk); #1;
         cyc++;
         if (do_acc) begin
            sb_q.push_back(mul_ref(a, b));
            acc_cyc_q.push_back(cyc);
            if (last_acc >= 0) chk("sb initiation interval", PW'(cyc - last_acc), PW'(8));
            last_acc = cyc;
            n_acc++;
            a = rnd_op();
            b = rnd_op();
         end
      end
      chk("sb completed", PW'(n_out), PW'(1000));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
